// File: rtl/mem_sched_pkg.sv
// Shared constants and tag pipeline entry type for the BRAM read-port scheduler.
// Imported by the scheduler top and its priority selector.
package mem_sched_pkg;

  localparam int MS_N       = 8;
  localparam int MS_ADDR_W  = 12;
  localparam int MS_DATA_W  = 64;
  localparam int MS_LATENCY = 2;

  typedef struct packed {
    logic            valid;
    logic [MS_N-1:0] id;
  } tag_t;

endpackage

// File: rtl/mem_port_rr_scheduler_rr_priority_select.sv
// Round-robin priority selector: one-hot grant, search starts above i_ptr.
// Ports: i_req (candidates), i_ptr (one-hot last served), o_grant (one-hot).
module rr_priority_select
  import mem_sched_pkg::*;
#(
  parameter int N = MS_N
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_ptr,
  output logic [N-1:0] o_grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_m_first;
  logic [N-1:0] w_u_first;

  // Thermometer of indices strictly above the pointer.
  assign w_mask    = ~(i_ptr | (i_ptr - 1'b1));
  assign w_masked  = i_req & w_mask;
  // Isolate lowest set bit (fixed-priority pass).
  assign w_m_first = w_masked & (~w_masked + 1'b1);
  assign w_u_first = i_req & (~i_req + 1'b1);

  assign o_grant = (|w_masked) ? w_m_first : w_u_first;

endmodule

// File: rtl/mem_port_rr_scheduler.sv
// Shares one fixed-latency BRAM read port among N requesters, round-robin.
// Ports: req_* requests, mem_* BRAM port, rsp_* one-hot responses, busy.
module mem_port_rr_scheduler
  import mem_sched_pkg::*;
#(
  parameter int N           = MS_N,
  parameter int ADDR_W      = MS_ADDR_W,
  parameter int DATA_W      = MS_DATA_W,
  parameter int MEM_LATENCY = MS_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*ADDR_W-1:0] req_addr,
  output logic [N-1:0]        req_ready,
  input  logic                mem_ready,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [N-1:0]        rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy
);

  logic [N-1:0]      r_ptr;
  tag_t              r_pipe [MEM_LATENCY];
  logic [N-1:0]      w_cand;
  logic [N-1:0]      w_grant;
  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;

  assign w_cand = req_valid & {N{mem_ready}};

  rr_priority_select #(
    .N(N)
  ) u_sel (
    .i_req  (w_cand),
    .i_ptr  (r_ptr),
    .o_grant(w_grant)
  );

  assign w_issue = |w_grant;

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign req_ready = w_grant;
  assign mem_en    = w_issue;
  assign mem_addr  = w_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {1'b1, {(N-1){1'b0}}};
    end else if (w_issue) begin
      r_ptr <= w_grant;
    end
  end

  // Tags shift every cycle; mem_ready never stalls returning reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= '{valid: w_issue, id: w_grant};
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign rsp_valid = r_pipe[MEM_LATENCY-1].valid ?
                     r_pipe[MEM_LATENCY-1].id : '0;
  assign rsp_data  = (|rsp_valid) ? mem_rdata : '0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      busy = busy | r_pipe[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      assert ($onehot0(rsp_valid));
      assert ($onehot(r_ptr));
      assert (!mem_en || mem_ready);
    end
  end

endmodule

// File: tb/tb_mem_port_rr_scheduler.sv
// Self-checking bench for mem_port_rr_scheduler with a BRAM model,
// directed scenarios and a randomized scoreboard run.
module tb_mem_port_rr_scheduler;
  import mem_sched_pkg::*;

  localparam int N  = MS_N;
  localparam int AW = MS_ADDR_W;
  localparam int DW = MS_DATA_W;
  localparam int L  = MS_LATENCY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic          mem_ready = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_rr_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .mem_ready(mem_ready),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] bram_f(input logic [AW-1:0] a);
    return {20'hABCDE, a, 20'h13579, a ^ 12'hFFF};
  endfunction

  // BRAM: data valid L cycles after mem_en, garbage otherwise; no reset.
  logic          b_vld  [L];
  logic [AW-1:0] b_addr [L];
  logic [DW-1:0] garb;

  initial begin
    for (int i = 0; i < L; i++) begin
      b_vld[i]  = 1'b0;
      b_addr[i] = '0;
    end
    garb = 64'hDEAD_BEEF_0BAD_F00D;
  end

  always @(posedge clk) begin
    b_vld[0]  <= mem_en;
    b_addr[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      b_vld[i]  <= b_vld[i-1];
      b_addr[i] <= b_addr[i-1];
    end
    garb <= {$urandom, $urandom} | 64'h1;
  end

  assign mem_rdata = b_vld[L-1] ? bram_f(b_addr[L-1]) : garb;

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== '0) begin
      n_err++;
      $display("FAIL reset rsp_valid got %h exp 0", rsp_valid);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset busy got %b exp 0", busy);
    end
    n_vec++;
    if (req_ready !== '0 || mem_en !== 1'b0 || mem_addr !== '0) begin
      n_err++;
      $display("FAIL reset issue got rdy=%h en=%b addr=%h exp 0",
               req_ready, mem_en, mem_addr);
    end
    n_vec++;
    if (rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset rsp_data got %h exp 0", rsp_data);
    end
  endtask

  task automatic test_all_request();
    logic [N-1:0]  eg, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eb;
    for (int i = 0; i < N; i++) set_addr(i, 12'h100 + 12'(i));
    mem_ready = 1'b1;
    for (int k = 0; k <= N + L; k++) begin
      req_valid = (k < N) ? '1 : '0;
      eg = '0;
      ea = '0;
      if (k < N) begin
        eg[k] = 1'b1;
        ea = 12'h100 + 12'(k);
      end
      er = '0;
      ed = '0;
      if (k >= L && k < N + L) begin
        er[k-L] = 1'b1;
        ed = bram_f(12'h100 + 12'(k - L));
      end
      eb = (k >= 1) && (k <= N + L - 1);
      #1;
      n_vec++;
      if (req_ready !== eg || mem_addr !== ea) begin
        n_err++;
        $display("FAIL all_req grant k=%0d got %h/%h exp %h/%h",
                 k, req_ready, mem_addr, eg, ea);
      end
      n_vec++;
      if (rsp_valid !== er || rsp_data !== ed) begin
        n_err++;
        $display("FAIL all_req rsp k=%0d got %h/%h exp %h/%h",
                 k, rsp_valid, rsp_data, er, ed);
      end
      n_vec++;
      if (busy !== eb) begin
        n_err++;
        $display("FAIL all_req busy k=%0d got %b exp %b", k, busy, eb);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alternate();
    logic [N-1:0] eg, er;
    logic [DW-1:0] ed;
    for (int k = 0; k < 4 + L; k++) begin
      req_valid = (k < 4) ? 8'h81 : 8'h00;
      eg = (k < 4) ? ((k % 2 == 0) ? 8'h01 : 8'h80) : 8'h00;
      er = '0;
      ed = '0;
      if (k >= L) begin
        er = ((k - L) % 2 == 0) ? 8'h01 : 8'h80;
        ed = bram_f(((k - L) % 2 == 0) ? 12'h100 : 12'h107);
      end
      #1;
      n_vec++;
      if (req_ready !== eg) begin
        n_err++;
        $display("FAIL alternate grant k=%0d got %h exp %h",
                 k, req_ready, eg);
      end
      n_vec++;
      if (rsp_valid !== er || rsp_data !== ed) begin
        n_err++;
        $display("FAIL alternate rsp k=%0d got %h/%h exp %h/%h",
                 k, rsp_valid, rsp_data, er, ed);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sole();
    int hits;
    logic [N-1:0] eg;
    hits = 0;
    for (int k = 0; k < 5 + L + 1; k++) begin
      req_valid = (k < 5) ? 8'h80 : 8'h00;
      eg = (k < 5) ? 8'h80 : 8'h00;
      #1;
      n_vec++;
      if (req_ready !== eg) begin
        n_err++;
        $display("FAIL sole grant k=%0d got %h exp %h", k, req_ready, eg);
      end
      if (rsp_valid == 8'h80 && rsp_data == bram_f(12'h107)) hits++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (hits !== 5) begin
      n_err++;
      $display("FAIL sole responses got %0d exp 5", hits);
    end
  endtask

  task automatic test_mem_stall();
    logic [7:0]  t_rv [8] = '{8'h06, 8'h04, 8'hFF, 8'hFF,
                              8'hFF, 8'hFF, 8'h00, 8'h00};
    logic        t_mr [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic [7:0]  t_eg [8] = '{8'h02, 8'h04, 8'h00, 8'h00,
                              8'h00, 8'h08, 8'h00, 8'h00};
    logic [7:0]  t_er [8] = '{8'h00, 8'h00, 8'h02, 8'h04,
                              8'h00, 8'h00, 8'h00, 8'h08};
    logic [11:0] t_ra [8] = '{12'h0, 12'h0, 12'h101, 12'h102,
                              12'h0, 12'h0, 12'h0, 12'h103};
    logic        t_eb [8] = '{0, 1, 1, 1, 0, 0, 1, 1};
    logic [DW-1:0] ed;
    for (int k = 0; k < 8; k++) begin
      req_valid = t_rv[k];
      mem_ready = t_mr[k];
      ed = (t_er[k] != 0) ? bram_f(t_ra[k]) : '0;
      #1;
      n_vec++;
      if (req_ready !== t_eg[k] || mem_en !== (t_eg[k] != 0)) begin
        n_err++;
        $display("FAIL stall grant k=%0d got %h en=%b exp %h",
                 k, req_ready, mem_en, t_eg[k]);
      end
      n_vec++;
      if (rsp_valid !== t_er[k] || rsp_data !== ed) begin
        n_err++;
        $display("FAIL stall rsp k=%0d got %h/%h exp %h/%h",
                 k, rsp_valid, rsp_data, t_er[k], ed);
      end
      n_vec++;
      if (busy !== t_eb[k]) begin
        n_err++;
        $display("FAIL stall busy k=%0d got %b exp %b", k, busy, t_eb[k]);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    set_addr(0, 12'h0A5);
    req_valid = 8'h01;
    #1;
    n_vec++;
    if (req_ready !== 8'h01 || mem_addr !== 12'h0A5) begin
      n_err++;
      $display("FAIL rst_mid issue got %h/%h exp 01/0a5",
               req_ready, mem_addr);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (rsp_valid !== '0 || rsp_data !== '0) begin
        n_err++;
        $display("FAIL rst_mid rsp k=%0d got %h/%h exp 0",
                 k, rsp_valid, rsp_data);
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid busy k=%0d got %b exp 0", k, busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] addr;
  } exp_t;

  task automatic test_random(input int cycles);
    exp_t          q[$];
    exp_t          e;
    logic          pend [N];
    logic [AW-1:0] paddr [N];
    int            waitc [N];
    int            m_ptr;
    int            gi;
    int            idx;
    logic [N-1:0]  eg, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eb;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
      waitc[i] = 0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom);
          set_addr(i, paddr[i]);
        end
        req_valid[i] = pend[i];
      end
      mem_ready = ($urandom_range(0, 7) != 0);
      gi = -1;
      if (mem_ready) begin
        for (int j = 1; j <= N; j++) begin
          idx = (m_ptr + j) % N;
          if (gi < 0 && pend[idx]) gi = idx;
        end
      end
      eg = '0;
      ea = '0;
      if (gi >= 0) begin
        eg[gi] = 1'b1;
        ea = paddr[gi];
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      er = '0;
      ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        er[q[0].id] = 1'b1;
        ed = bram_f(q[0].addr);
      end
      eb = (q.size() > 0);
      #1;
      n_vec++;
      if (req_ready !== eg || mem_en !== (gi >= 0) || mem_addr !== ea) begin
        n_err++;
        $display("FAIL random grant c=%0d got %h/%b/%h exp %h/%h",
                 cyc, req_ready, mem_en, mem_addr, eg, ea);
      end
      n_vec++;
      if (rsp_valid !== er || rsp_data !== ed) begin
        n_err++;
        $display("FAIL random rsp c=%0d got %h/%h exp %h/%h",
                 cyc, rsp_valid, rsp_data, er, ed);
      end
      n_vec++;
      if (busy !== eb) begin
        n_err++;
        $display("FAIL random busy c=%0d got %b exp %b", cyc, busy, eb);
      end
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) waitc[i] = 0;
          else if (req_valid[i]) waitc[i]++;
          if (req_valid[i] && !req_ready[i]) begin
            n_vec++;
            if (waitc[i] > N - 1) begin
              n_err++;
              $display("FAIL random fairness c=%0d req=%0d waited %0d max %0d",
                       cyc, i, waitc[i], N - 1);
            end
          end
        end
      end
      if (gi >= 0) begin
        e.due  = cyc + L;
        e.id   = gi;
        e.addr = paddr[gi];
        q.push_back(e);
        pend[gi] = 1'b0;
        m_ptr = gi;
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_all_request();
    test_alternate();
    test_sole();
    test_mem_stall();
    test_reset_midflight();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_rr_scheduler.md
Name: mem_port_rr_scheduler

Overview:
- Shares one fixed-latency BRAM read port among N engine requesters, e.g. the regex cores fetching instructions.
- Round-robin grant: the most recently served requester becomes lowest priority.
- Issues one read per cycle and tracks in-flight reads in a tag pipeline.
- Returns each read result to its owner exactly MEM_LATENCY cycles after issue.

Parameters:
- N, 8: number of requesters (≥2).
- ADDR_W, 12: memory address width.
- DATA_W, 64: memory data width.
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  N  per-requester read request
- req_addr  in  N*ADDR_W  packed addresses; slice i belongs to requester i
- req_ready  out  N  per-requester accept, at most one bit set
- mem_ready  in  1  port available; low blocks issue
- mem_en  out  1  read strobe to BRAM
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  BRAM read data, valid MEM_LATENCY cycles after mem_en
- rsp_valid  out  N  one-hot response strobe
- rsp_data  out  DATA_W  response data, broadcast to all requesters
- busy  out  1  at least one read in flight

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. Effects of rst:
  - priority pointer set to one-hot bit N-1, so index 0 has highest priority;
  - tag pipeline cleared;
  - rsp_valid=0 and busy=0 from the first cycle after rst.
- Grant (combinational, same cycle):
  - Candidates are the req_valid bits, masked by mem_ready.
  - Search starts at the index above the pointer and wraps modulo N.
  - The first set bit wins and drives req_ready.
  - Resulting order: pointer index is lowest priority, pointer+1 is highest.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold req_valid and their addr slice stable until accepted.
  - req_ready never asserts while req_valid is low.
- Issue, in the transfer cycle:
  - mem_en=1 and mem_addr = the granted slice;
  - otherwise mem_en=0 and mem_addr=0.
- Pointer update:
  - On transfer, the pointer becomes the one-hot of the granted index on the next edge.
  - With no transfer, the pointer holds.
  - A sole requester is granted on every cycle; the lowest-priority index is never starved out.
- Tag pipeline:
  - Depth MEM_LATENCY; each entry is {valid, one-hot id}.
  - Stage 0 loads {mem_en, grant} each cycle; the pipeline shifts unconditionally.
  - mem_ready does not stall the pipeline.
- Response:
  - rsp_valid = id of the last stage, gated by its valid.
  - rsp_data = mem_rdata while any rsp_valid bit is set, else 0.
  - Requesters must accept responses; there is no response backpressure.
- Latency and throughput:
  - Exactly MEM_LATENCY cycles from transfer to rsp_valid.
  - Throughput is one read per cycle sustained.
- busy = OR of the valid bits over all pipeline stages.
- mem_ready low: no grants and the pointer holds; in-flight responses still return on schedule.
- Simultaneous events: a new issue and a response in the same cycle are independent. The same requester may be granted while its previous response is emerging.
- Reset mid-operation: in-flight reads are dropped and no rsp_valid follows. mem_rdata arriving after reset is ignored.
- Assertions:
  - $onehot0(req_ready) and $onehot0(rsp_valid);
  - pointer always one-hot;
  - mem_en implies mem_ready.

Decomposition:
- Shared package mem_sched_pkg:
  - default constants N, ADDR_W, DATA_W, MEM_LATENCY;
  - typedef tag_t, the pipeline entry struct {logic valid; logic [N-1:0] id}.
- Sub-module rr_priority_select, combinational:
  - inputs: req, pointer; output: one-hot grant.
  - Built from a thermometer mask plus two fixed-priority passes: the masked pass wins if non-zero, otherwise the unmasked pass.
- Pointer register, tag pipeline and muxing stay in the top module.

Test Plan:
- After rst, req_valid=8'hFF held for 8 cycles, mem_ready=1 -> grant order 0,1,...,7. rsp_valid one-hot 0..7 appears on cycles 3..10 with the BRAM model data.
- req_valid=8'b1000_0001 held for 4 cycles -> grants alternate 0,7,0,7.
- Only requester 7 requests for 5 cycles -> granted every cycle and 5 responses returned.
- mem_ready=0 for 3 cycles with 2 reads in flight -> no req_ready, pointer unchanged, both responses still arrive at latency 2.
- rst asserted 1 cycle after issuing a read to addr 12'h0A5 -> rsp_valid stays 0, busy=0 on the next cycle.
- Randomized 10k cycles against a scoreboard -> every accepted addr returns matching data to its owner after MEM_LATENCY cycles. No requester waits more than N-1 grants.
